// File: rtl/systolic_drain_requant.sv
// systolic_drain_requant: snapshots the systolic accumulator tile on capture and
// streams it row by row, requantizing each INT32 element to INT8 on the way out.
//   clk, rst_n          clock, asynchronous active-low reset
//   capture             single-cycle snapshot request
//   c_in_flat           accumulators, element (r,c) at [(r*N_COLS+c)*ACC_W +: ACC_W]
//   shift_amt, relu_en  requant config, latched together with the snapshot
//   out_valid/out_ready beat handshake
//   out_data            requantized row, lane c at [c*OUT_W +: OUT_W]
//   out_row, out_last   index of the current beat, last-row flag
//   busy                snapshot held and not yet fully drained
//   done                pulse after the final beat transfers
//   capture_drop        pulse when a capture was ignored because busy
module systolic_drain_requant #(
   parameter int N_ROWS  = 14,
   parameter int N_COLS  = 14,
   parameter int ACC_W   = 32,
   parameter int OUT_W   = 8,
   parameter int SHIFT_W = 5
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              capture,
   input  logic [N_ROWS*N_COLS*ACC_W-1:0]    c_in_flat,
   input  logic [SHIFT_W-1:0]                shift_amt,
   input  logic                              relu_en,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [N_COLS*OUT_W-1:0]           out_data,
   output logic [$clog2(N_ROWS)-1:0]         out_row,
   output logic                              out_last,
   output logic                              busy,
   output logic                              done,
   output logic                              capture_drop
);
   localparam int RW = $clog2(N_ROWS);
   localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
   localparam logic signed [ACC_W:0] MINV = -MAXV - 1;

   typedef enum logic {IDLE, STREAM} state_t;

   state_t                   state_q, state_d;
   logic [RW-1:0]            row_q, row_d;
   logic                     done_q, drop_q;
   logic signed [ACC_W-1:0]  snap_q [N_ROWS][N_COLS];
   logic [SHIFT_W-1:0]       shift_q;
   logic                     relu_q;
   logic                     xfer, last, fin, cap_ok;

   assign xfer   = (state_q == STREAM) && out_ready;
   assign last   = row_q == RW'(N_ROWS - 1);
   assign fin    = xfer && last;
   // A capture landing on the final transfer starts the next tile without a bubble.
   assign cap_ok = capture && ((state_q == IDLE) || fin);

   always_comb begin
      state_d = cap_ok ? STREAM : fin ? IDLE : state_q;
      row_d   = (cap_ok || fin) ? '0 : xfer ? row_q + 1'b1 : row_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         row_q   <= '0;
         done_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         done_q  <= fin;
         drop_q  <= capture && (state_q == STREAM) && !fin;
      end
   end

   // Snapshot storage needs no reset: it is never observable while out_valid is low.
   always_ff @(posedge clk) begin
      if (cap_ok) begin
         for (int r = 0; r < N_ROWS; r++)
            for (int c = 0; c < N_COLS; c++)
               snap_q[r][c] <= c_in_flat[(r*N_COLS+c)*ACC_W +: ACC_W];
         shift_q <= shift_amt;
         relu_q  <= relu_en;
      end
   end

   assign out_valid    = state_q == STREAM;
   assign busy         = state_q == STREAM;
   assign out_row      = row_q;
   assign out_last     = (state_q == STREAM) && last;
   assign done         = done_q;
   assign capture_drop = drop_q;

   for (genvar c = 0; c < N_COLS; c++) begin : g_lane
      logic signed [ACC_W-1:0] x;
      logic signed [ACC_W:0]   v, rnd, r;
      assign x   = snap_q[row_q][c];
      // One extra bit so the rounding addend cannot overflow a max-positive input.
      assign v   = (relu_q && x[ACC_W-1]) ? '0 : {x[ACC_W-1], x};
      assign rnd = (ACC_W+1)'(1) << (shift_q - 1'b1);
      assign r   = (shift_q == '0) ? v : (v + rnd) >>> shift_q;
      assign out_data[c*OUT_W +: OUT_W] = !out_valid ? '0 :
                                          (r > MAXV) ? MAXV[OUT_W-1:0] :
                                          (r < MINV) ? MINV[OUT_W-1:0] : r[OUT_W-1:0];
   end
endmodule

// File: tb/tb_systolic_drain_requant.sv
// tb_systolic_drain_requant: directed self-checking bench for systolic_drain_requant.
module tb_systolic_drain_requant;
   logic          clk = 1'b0, rst_n = 1'b0, capture = 1'b0, relu_en = 1'b0, out_ready = 1'b0;
   logic [6271:0] c_in_flat = '0;
   logic [4:0]    shift_amt = '0;
   logic          out_valid, out_last, busy, done, capture_drop;
   logic [111:0]  out_data;
   logic [3:0]    out_row;
   int            checks = 0, errors = 0;

   systolic_drain_requant dut (
      .clk(clk), .rst_n(rst_n), .capture(capture), .c_in_flat(c_in_flat),
      .shift_amt(shift_amt), .relu_en(relu_en), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
      .out_last(out_last), .busy(busy), .done(done), .capture_drop(capture_drop)
   );

   always #5 clk = ~clk;

   function automatic logic signed [7:0] lane(int c);
      return out_data[c*8 +: 8];
   endfunction

   task automatic set_c(int r, int c, int v);
      c_in_flat[(r*14+c)*32 +: 32] = v;
   endtask

   task automatic fill_basic();
      for (int r = 0; r < 14; r++)
         for (int c = 0; c < 14; c++) set_c(r, c, r*16 + c);
   endtask

   task automatic start(int sh, bit re);
      capture = 1'b1; shift_amt = 5'(sh); relu_en = re;
      @(negedge clk);
      capture = 1'b0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      repeat (15) @(negedge clk);
   endtask

   task automatic test_reset();
      checks++;
      if ({out_valid, busy, out_last, done, capture_drop, out_row, out_data} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got v%b b%b l%b d%b cd%b row%0d data%h want all 0",
                  out_valid, busy, out_last, done, capture_drop, out_row, out_data);
      end
   endtask

   task automatic test_basic();
      fill_basic();
      out_ready = 1'b1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle_busy got %b want 0", busy); end
      start(0, 0);
      for (int r = 0; r < 14; r++) begin
         checks++;
         if ({out_valid, busy, out_last, done, out_row} !== {1'b1, 1'b1, r == 13, 1'b0, 4'(r)}) begin
            errors++;
            $display("FAIL basic_ctrl beat %0d got v%b b%b l%b d%b row%0d", r, out_valid, busy, out_last, done, out_row);
         end
         for (int c = 0; c < 14; c++) begin
            int e = (r*16 + c > 127) ? 127 : r*16 + c;
            checks++;
            if (lane(c) !== e) begin errors++; $display("FAIL basic_data r%0d c%0d got %0d want %0d", r, c, lane(c), e); end
         end
         @(negedge clk);
      end
      checks++;
      if ({done, out_valid, busy} !== 3'b100) begin
         errors++; $display("FAIL basic_done got d%b v%b b%b want 1 0 0", done, out_valid, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
   endtask

   task automatic test_round_sat();
      int e[4] = '{1, 2, -1, 127};
      c_in_flat = '0;
      set_c(0, 0, 5); set_c(0, 1, 6); set_c(0, 2, -6); set_c(0, 3, 40000);
      start(2, 0);
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (lane(c) !== e[c]) begin errors++; $display("FAIL round_shift2 c%0d got %0d want %0d", c, lane(c), e[c]); end
      end
      drain();
      c_in_flat = '0;
      set_c(0, 0, -40000);
      start(0, 0);
      checks++;
      if (lane(0) !== -128) begin errors++; $display("FAIL sat_neg got %0d want -128", lane(0)); end
      drain();
      c_in_flat = '0;
      set_c(0, 0, 32'h7FFF_FFFF); set_c(0, 1, 32'h8000_0000);
      start(1, 0);
      checks++;
      if (lane(0) !== 127) begin errors++; $display("FAIL sat_maxpos got %0d want 127", lane(0)); end
      checks++;
      if (lane(1) !== -128) begin errors++; $display("FAIL sat_maxneg got %0d want -128", lane(1)); end
      drain();
   endtask

   task automatic test_relu();
      c_in_flat = '0;
      set_c(0, 0, -300); set_c(0, 1, 300);
      start(1, 1);
      checks++;
      if ({lane(0), lane(1)} !== {8'sd0, 8'sd127}) begin
         errors++; $display("FAIL relu_on got %0d %0d want 0 127", lane(0), lane(1));
      end
      drain();
      start(1, 0);
      checks++;
      if ({lane(0), lane(1)} !== {-8'sd128, 8'sd127}) begin
         errors++; $display("FAIL relu_off got %0d %0d want -128 127", lane(0), lane(1));
      end
      drain();
   endtask

   task automatic test_backpressure();
      int exp_row = 0, xfers = 0, cyc = 0;
      for (int r = 0; r < 14; r++)
         for (int c = 0; c < 14; c++) set_c(r, c, r*9 - c*5);
      start(0, 0);
      c_in_flat = '1;
      while (xfers < 14 && cyc < 100) begin
         out_ready = (cyc % 3 == 0);
         checks++;
         if ({out_valid, out_last, out_row} !== {1'b1, exp_row == 13, 4'(exp_row)}) begin
            errors++; $display("FAIL bp_ctrl cyc %0d got v%b l%b row%0d want row %0d", cyc, out_valid, out_last, out_row, exp_row);
         end
         for (int c = 0; c < 14; c++) begin
            checks++;
            if (lane(c) !== exp_row*9 - c*5) begin
               errors++; $display("FAIL bp_data cyc %0d c%0d got %0d want %0d", cyc, c, lane(c), exp_row*9 - c*5);
            end
         end
         @(negedge clk);
         if (out_ready) begin xfers++; exp_row++; end
         cyc++;
      end
      checks++;
      if (xfers !== 14) begin errors++; $display("FAIL bp_xfers got %0d want 14", xfers); end
      checks++;
      if ({done, out_valid} !== 2'b10) begin errors++; $display("FAIL bp_done got d%b v%b want 1 0", done, out_valid); end
      out_ready = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_collision();
      fill_basic();
      out_ready = 1'b1;
      start(0, 0);
      repeat (5) @(negedge clk);
      capture = 1'b1; shift_amt = 5'd3; c_in_flat = '0;
      @(negedge clk);
      capture = 1'b0;
      checks++;
      if ({capture_drop, out_row} !== {1'b1, 4'd6}) begin
         errors++; $display("FAIL drop_pulse got cd%b row%0d want 1 6", capture_drop, out_row);
      end
      for (int c = 0; c < 14; c++) begin
         checks++;
         if (lane(c) !== 96 + c) begin errors++; $display("FAIL drop_data c%0d got %0d want %0d", c, lane(c), 96 + c); end
      end
      @(negedge clk);
      checks++;
      if (capture_drop !== 1'b0) begin errors++; $display("FAIL drop_once got %b want 0", capture_drop); end
      repeat (6) @(negedge clk);
      checks++;
      if ({out_row, out_last} !== {4'd13, 1'b1}) begin
         errors++; $display("FAIL b2b_last got row%0d l%b want 13 1", out_row, out_last);
      end
      for (int c = 0; c < 14; c++) set_c(0, c, 100 + 2*c);
      start(1, 0);
      checks++;
      if ({out_valid, busy, done, capture_drop, out_row} !== {4'b1110, 4'd0}) begin
         errors++; $display("FAIL b2b_ctrl got v%b b%b d%b cd%b row%0d want 1 1 1 0 0", out_valid, busy, done, capture_drop, out_row);
      end
      for (int c = 0; c < 14; c++) begin
         checks++;
         if (lane(c) !== 50 + c) begin errors++; $display("FAIL b2b_data c%0d got %0d want %0d", c, lane(c), 50 + c); end
      end
      drain();
   endtask

   task automatic test_async_reset();
      fill_basic();
      out_ready = 1'b1;
      start(0, 0);
      repeat (7) @(negedge clk);
      checks++;
      if (out_row !== 4'd7) begin errors++; $display("FAIL ar_pre row got %0d want 7", out_row); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({out_valid, busy, out_row, out_data} !== '0) begin
         errors++; $display("FAIL ar_immediate got v%b b%b row%0d want 0", out_valid, busy, out_row);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start(0, 0);
      for (int r = 0; r < 14; r++) begin
         checks++;
         if ({out_valid, out_row} !== {1'b1, 4'(r)} || lane(0) !== ((r*16 > 127) ? 127 : r*16)) begin
            errors++; $display("FAIL ar_redrain beat %0d got v%b row%0d lane0 %0d", r, out_valid, out_row, lane(0));
         end
         @(negedge clk);
      end
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL ar_done got %b want 1", done); end
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_basic();
      test_round_sat();
      test_relu();
      test_backpressure();
      test_collision();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end
endmodule

// File: doc/systolic_drain_requant.md
Name: systolic_drain_requant

Overview:
- Downstream stage of the 14×14 sparse systolic array.
- On a capture pulse, snapshots all N_ROWS×N_COLS INT32 accumulators in one cycle, so the array may clear and start the next tile on the following cycle.
- Streams the snapshot row by row over a valid/ready interface. Each element is requantized to INT8 (optional ReLU, rounding arithmetic right shift, saturation) on the way out.

Parameters:
N_ROWS, 14, rows in array / beats per tile
N_COLS, 14, lanes per output beat
ACC_W, 32, accumulator width (signed)
OUT_W, 8, output element width (signed)
SHIFT_W, 5, width of requant shift amount

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
capture  in  1  snapshot request (single-cycle pulse)
c_in_flat  in  N_ROWS*N_COLS*ACC_W  accumulators; element (r,c) at bits [(r*N_COLS+c)*ACC_W +: ACC_W]
shift_amt  in  SHIFT_W  right-shift amount, sampled with capture
relu_en  in  1  clamp negatives to 0 before shift, sampled with capture
out_valid  out  1  beat available
out_ready  in  1  consumer accepts beat
out_data  out  N_COLS*OUT_W  requantized row; lane c at [c*OUT_W +: OUT_W]
out_row  out  $clog2(N_ROWS)  row index of current beat
out_last  out  1  current beat is row N_ROWS-1
busy  out  1  snapshot held, not fully drained
done  out  1  one-cycle pulse after final beat transfers
capture_drop  out  1  one-cycle pulse: capture ignored because busy

Behaviour:
- Reset: all outputs 0; state IDLE; row_ptr=0; snapshot contents don't-care, never visible while out_valid=0.
- States: IDLE, STREAM.
- IDLE, capture=1:
  - Latch all c_in_flat, shift_amt and relu_en on that edge.
  - Go to STREAM with row_ptr=0.
  - out_valid=busy=1 from the next cycle (capture-to-first-beat latency: 1 cycle).
- STREAM:
  - out_valid=1, out_row=row_ptr, out_last=(row_ptr==N_ROWS-1).
  - out_data is a combinational function of snapshot row row_ptr and the latched config; it is stable while out_valid && !out_ready.
- Transfer is out_valid && out_ready:
  - Non-last beat: row_ptr+1.
  - Last beat: row_ptr wraps to 0, state goes to IDLE, busy=0 and done=1 next cycle.
- Stalls: out_ready low holds all state indefinitely. out_valid never drops before transfer.
- capture in STREAM:
  - Without a last-beat transfer in the same cycle: ignored; snapshot unchanged; capture_drop=1 next cycle.
  - In the same cycle as a last-beat transfer: accepted. New snapshot and config are latched; state stays STREAM; row_ptr=0; out_valid stays 1 (back-to-back tiles, no bubble); done still pulses; capture_drop=0.
- Requant per element x (signed ACC_W), computed in ACC_W+1 bits:
  - v = (relu_en && x<0) ? 0 : x.
  - If shift_amt==0: r = v. Otherwise: r = (v + (1<<(shift_amt-1))) >>> shift_amt (round half up, arithmetic shift).
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. No wrap allowed; the +rounding term must not overflow (hence the extra bit).
- Reset mid-stream: immediate return to IDLE, all outputs 0; the partially drained tile is lost.
- Only registered state drives out_valid/out_row/out_last/busy/done/capture_drop; out_data has no combinational path from inputs other than the snapshot.

Test Plan:
- Basic drain: c(r,c)=r*16+c, shift=0, relu=0, out_ready=1; capture -> 14 beats on cycles 1..14; beat r lane c = min(r*16+c, 127); out_last only on beat 13; done pulses on cycle 15; busy high cycles 1..14.
- Rounding/saturation: c(0,0..3)={5,6,-6,40000}, shift=2 -> 1, 2, -1 (-6+2=-4, >>>2=-1), 127. Also c=-40000, shift=0 -> -128. Also c=0x7FFFFFFF, shift=1 -> 127 with no wrap.
- ReLU: c(0,0..1)={-300,300}, relu_en=1, shift=1 -> 0, 127; same with relu_en=0 -> -128, 127.
- Backpressure: out_ready toggles 1,0,0,1,...; out_data/out_row stable during stalls; exactly 14 transfers, rows 0..13 in order; change c_in_flat after capture -> outputs unaffected.
- Capture collisions: capture at beat 5 -> capture_drop pulse, data unchanged. Capture coincident with last-beat transfer -> beat 0 of the new tile appears next cycle with out_valid continuous, done pulses, new shift_amt applied.
- Async reset asserted mid-stream at beat 7 -> out_valid, busy and out_row go 0 immediately. After release, a new capture drains a full 14 beats starting at row 0.
